// File: rtl/sample_feeder.sv
// ---------------------------------------------------------------------------
// sample_feeder
//   Buffers non-uniform upstream samples in a small FIFO and presents them to
//   the PE array one per slot. A frame is 8 slots. Every slot lasts timing+1
//   clk30x cycles. The slot period is re-latched only at frame boundaries.
//
// Ports
//   clk30x      : single clock, rising edge
//   reset       : asynchronous, active-low reset
//   enable      : request to stream frames
//   period      : slot length minus 1 (cycles), sampled at frame start
//   in_word     : upstream sample
//   in_valid    : in_word is valid
//   in_ready    : FIFO can accept a word
//   inputword   : word on the PE array input bus (0 when idle or starved)
//   timing      : latched slot period for the PE timing inputs
//   slot_strobe : one-cycle pulse when a new word appears on inputword
//   frame_start : one-cycle pulse with slot_strobe for slot 0
//   word_index  : slot number 0..7 of the current inputword
//   underrun    : sticky; some slot found the FIFO empty
//   fill        : current FIFO occupancy
// ---------------------------------------------------------------------------
module sample_feeder #(
    parameter int WORDLENGTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic                    clk30x,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [31:0]             period,
    input  logic [WORDLENGTH-1:0]   in_word,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WORDLENGTH-1:0]   inputword,
    output logic [31:0]             timing,
    output logic                    slot_strobe,
    output logic                    frame_start,
    output logic [2:0]              word_index,
    output logic                    underrun,
    output logic [$clog2(DEPTH):0]  fill
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_LVL = DEPTH[AW:0];

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic                  state;
    logic [31:0]           counter;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [WORDLENGTH-1:0] mem [DEPTH];

    logic push;
    logic pop;
    logic nonempty;
    logic start;
    logic boundary;
    logic wrap;
    logic stop;

    assign in_ready = (fill < DEPTH_LVL);
    assign push     = in_valid && in_ready;
    // Registered fill is the pre-push occupancy, so a word pushed this cycle
    // is never visible to a pop in the same cycle.
    assign nonempty = (fill != '0);

    assign start    = (state == ST_IDLE) && enable && nonempty;
    assign boundary = (state == ST_RUN) && (counter == timing);
    assign wrap     = boundary && (word_index == 3'd7);
    assign stop     = wrap && !enable;
    assign pop      = start || (boundary && !stop && nonempty);

    // Storage: no reset needed, contents are qualified by fill.
    always_ff @(posedge clk30x) begin
        if (push) begin
            mem[wr_ptr] <= in_word;
        end
    end

    always_ff @(posedge clk30x or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    always_ff @(posedge clk30x or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            counter     <= '0;
            timing      <= '0;
            inputword   <= '0;
            word_index  <= '0;
            slot_strobe <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            slot_strobe <= 1'b0;
            frame_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    counter <= '0;
                    if (start) begin
                        state       <= ST_RUN;
                        inputword   <= mem[rd_ptr];
                        timing      <= period;
                        word_index  <= '0;
                        slot_strobe <= 1'b1;
                        frame_start <= 1'b1;
                    end
                end
                default: begin
                    if (boundary) begin
                        counter <= '0;
                        if (stop) begin
                            state      <= ST_IDLE;
                            inputword  <= '0;
                            word_index <= '0;
                        end else begin
                            word_index  <= word_index + 3'd1;
                            slot_strobe <= 1'b1;
                            if (wrap) begin
                                frame_start <= 1'b1;
                                timing      <= period;
                            end
                            if (nonempty) begin
                                inputword <= mem[rd_ptr];
                            end else begin
                                inputword <= '0;
                                underrun  <= 1'b1;
                            end
                        end
                    end else begin
                        counter <= counter + 32'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_feeder.sv
// ---------------------------------------------------------------------------
// tb_sample_feeder
//   Directed scenarios followed by a randomized phase. A queue-based
//   reference model (slot countdown, sample queue) predicts every output
//   each cycle; explicit checks cover the streaming, backpressure, underrun,
//   stop-at-frame-end, period-change and reset scenarios.
// ---------------------------------------------------------------------------
module tb_sample_feeder;

    localparam int WL    = 16;
    localparam int DEPTH = 8;

    logic          clk30x;
    logic          reset;
    logic          enable;
    logic [31:0]   period;
    logic [WL-1:0] in_word;
    logic          in_valid;
    logic          in_ready;
    logic [WL-1:0] inputword;
    logic [31:0]   timing;
    logic          slot_strobe;
    logic          frame_start;
    logic [2:0]    word_index;
    logic          underrun;
    logic [3:0]    fill;

    sample_feeder #(.WORDLENGTH(WL), .DEPTH(DEPTH)) dut (
        .clk30x      (clk30x),
        .reset       (reset),
        .enable      (enable),
        .period      (period),
        .in_word     (in_word),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .inputword   (inputword),
        .timing      (timing),
        .slot_strobe (slot_strobe),
        .frame_start (frame_start),
        .word_index  (word_index),
        .underrun    (underrun),
        .fill        (fill)
    );

    initial clk30x = 1'b0;
    always #5 clk30x = ~clk30x;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WL-1:0] mq[$];
    bit            m_run;
    logic [WL-1:0] m_word;
    logic [31:0]   m_timing;
    logic [31:0]   m_left;     // cycles remaining in the current slot
    int unsigned   m_idx;
    bit            m_strobe;
    bit            m_fs;
    bit            m_under;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_run    = 1'b0;
        m_word   = '0;
        m_timing = '0;
        m_left   = '0;
        m_idx    = 0;
        m_strobe = 1'b0;
        m_fs     = 1'b0;
        m_under  = 1'b0;
    endtask

    task automatic model_edge();
        bit do_push;
        if (!reset) begin
            model_clear();
            return;
        end
        do_push  = in_valid && (mq.size() < DEPTH);
        m_strobe = 1'b0;
        m_fs     = 1'b0;
        if (!m_run) begin
            if (enable && mq.size() != 0) begin
                m_run    = 1'b1;
                m_word   = mq.pop_front();
                m_timing = period;
                m_left   = period;
                m_idx    = 0;
                m_strobe = 1'b1;
                m_fs     = 1'b1;
            end
        end else if (m_left != 0) begin
            m_left = m_left - 1;
        end else if (m_idx == 7 && !enable) begin
            m_run  = 1'b0;
            m_word = '0;
            m_idx  = 0;
        end else begin
            if (m_idx == 7) begin
                m_fs     = 1'b1;
                m_timing = period;
            end
            m_left   = m_timing;
            m_idx    = (m_idx + 1) % 8;
            m_strobe = 1'b1;
            if (mq.size() != 0) begin
                m_word = mq.pop_front();
            end else begin
                m_word  = '0;
                m_under = 1'b1;
            end
        end
        if (do_push) mq.push_back(in_word);
    endtask

    task automatic compare_all();
        chk("in_ready",    32'(in_ready),    32'(mq.size() < DEPTH));
        chk("fill",        32'(fill),        32'(mq.size()));
        chk("inputword",   32'(inputword),   32'(m_word));
        chk("timing",      timing,           m_timing);
        chk("slot_strobe", 32'(slot_strobe), 32'(m_strobe));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        chk("word_index",  32'(word_index),  m_idx);
        chk("underrun",    32'(underrun),    32'(m_under));
    endtask

    task automatic step();
        @(posedge clk30x);
        model_edge();
        #1;
        compare_all();
    endtask

    // Reset pulse applied away from the clock edge.
    task automatic reset_pulse();
        @(negedge clk30x);
        reset = 1'b0;
        #1;
        model_clear();
        compare_all();
        @(negedge clk30x);
        reset = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_fill"},      32'(fill),        32'd0);
        chk({tag, "_in_ready"},  32'(in_ready),    32'd1);
        chk({tag, "_inputword"}, 32'(inputword),   32'd0);
        chk({tag, "_timing"},    timing,           32'd0);
        chk({tag, "_strobe"},    32'(slot_strobe), 32'd0);
        chk({tag, "_fs"},        32'(frame_start), 32'd0);
        chk({tag, "_idx"},       32'(word_index),  32'd0);
        chk({tag, "_underrun"},  32'(underrun),    32'd0);
    endtask

    initial begin
        int seen;
        int frames;
        int cyc;
        int last;
        logic [WL-1:0] exp_words [8];

        reset    = 1'b0;
        enable   = 1'b0;
        period   = 32'd3;
        in_word  = '0;
        in_valid = 1'b0;
        model_clear();
        #2;
        check_reset_values("por");
        @(negedge clk30x);
        reset = 1'b1;
        step();

        // Fill to full with enable low; 9th word is held off.
        for (int k = 1; k <= 9; k++) begin
            in_valid = 1'b1;
            in_word  = WL'(k);
            step();
            if (k == 8) begin
                chk("full_fill",     32'(fill),     32'd8);
                chk("full_in_ready", 32'(in_ready), 32'd0);
            end
        end
        chk("ninth_blocked_fill", 32'(fill), 32'd8);

        // Stream frame of words 1..8, dropping enable during slot 4.
        enable = 1'b1;
        seen   = 0;
        for (int s = 0; s < 40; s++) begin
            step();
            if (m_strobe && seen < 8) begin
                chk("stream_word", 32'(inputword), 32'(seen + 1));
                seen++;
            end
            if (seen >= 1 && mq.size() == 8 && in_valid) begin
                chk("refill_fill", 32'(fill), 32'd8);
                in_valid = 1'b0;
            end
            if (m_strobe && m_idx == 4) enable = 1'b0;
        end
        chk("stream_count",     32'(seen),      32'd8);
        chk("stop_inputword",   32'(inputword), 32'd0);
        chk("stop_word_index",  32'(word_index),32'd0);
        chk("stream_underrun",  32'(underrun),  32'd0);
        chk("stop_fill",        32'(fill),      32'd1);

        // Underrun: three words, period 2.
        reset_pulse();
        period = 32'd2;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_word  = WL'(16'hA0 + k);
            step();
        end
        in_valid = 1'b0;
        enable   = 1'b1;
        exp_words[0] = 16'hA0; exp_words[1] = 16'hA1; exp_words[2] = 16'hA2;
        for (int k = 3; k < 8; k++) exp_words[k] = '0;
        seen = 0;
        for (int s = 0; s < 30; s++) begin
            step();
            if (m_strobe && seen < 8) begin
                chk("under_word", 32'(inputword), 32'(exp_words[seen]));
                if (seen == 3) chk("under_set", 32'(underrun), 32'd1);
                seen++;
                if (seen == 8) enable = 1'b0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_word  = WL'(16'hB0 + k);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("under_sticky", 32'(underrun), 32'd1);

        // Period change 3 -> 5 in slot 2 takes effect at next frame.
        reset_pulse();
        period = 32'd3;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_word  = WL'(16'h100 + k);
            step();
        end
        in_valid = 1'b0;
        enable   = 1'b1;
        frames = 0;
        cyc    = 0;
        last   = -1;
        for (int s = 0; s < 70; s++) begin
            step();
            cyc++;
            if (slot_strobe) begin
                if (last >= 0) chk("slot_gap", 32'(cyc - last), (frames >= 2) ? 32'd6 : 32'd4);
                last = cyc;
                if (frame_start) begin
                    frames++;
                    chk("frame_timing", timing, (frames >= 2) ? 32'd5 : 32'd3);
                end
            end
            if (m_strobe && m_idx == 2) period = 32'd5;
        end

        // Asynchronous reset mid-slot.
        @(posedge clk30x);
        model_edge();
        #3;
        reset = 1'b0;
        #1;
        model_clear();
        check_reset_values("midreset");
        @(negedge clk30x);
        reset = 1'b1;
        enable = 1'b0;
        step();
        chk("no_strobe_after_reset", 32'(slot_strobe), 32'd0);

        // Randomized traffic.
        for (int s = 0; s < 800; s++) begin
            in_valid = ($urandom_range(0, 99) < 45);
            in_word  = WL'($urandom);
            if ($urandom_range(0, 19) == 0) enable = ~enable;
            if ($urandom_range(0, 9) == 0) period = 32'($urandom_range(0, 4));
            if (s == 400) reset_pulse();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
